key_debounce: RTL and testbench

Conditions one raw push-button input into a clean, glitch-free level for the front-panel control path. Performs 2-flop synchronization, polarity normalization and counter-based debouncing. Sits directly upstream of the team's edge detector, which turns `key_level` into single-cycle press/release pulses. No pulse generation is done here.

---
 rtl/key_debounce_if.sv | 19 +
 rtl/key_debounce.sv | 94 +++++++++
 tb/tb_key_debounce.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/key_debounce_if.sv
// Button conditioning signals between the raw pin, the debouncer and the edge detector.
// The debouncer sits on the slave side.
interface key_debounce_if;
    logic key_in;
    logic key_level;
    logic key_busy;

    modport master (
        output key_in,
        input  key_level,
        input  key_busy
    );

    modport slave (
        input  key_in,
        output key_level,
        output key_busy
    );
endinterface

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, polarity normalization and counter-qualified
// debounce FSM producing a clean pressed/released level.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    key_debounce_if.slave kb
);
    localparam int            CW       = ($clog2(DEBOUNCE_CYCLES) > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic          IDLE_PIN = ACTIVE_LOW;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          sync0_q;
    logic          sync1_q;
    logic          level_q;
    logic          s;

    // Only sync0_q samples the asynchronous pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync0_q <= IDLE_PIN;
            sync1_q <= IDLE_PIN;
        end else begin
            sync0_q <= kb.key_in;
            sync1_q <= sync0_q;
        end
    end

    assign s = sync1_q ^ ACTIVE_LOW;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            case (state_q)
                RELEASED: begin
                    if (s) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state_q <= RELEASED;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= PRESSED;
                        level_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    // A single disagreeing sample drops the partial count entirely.
                    if (s) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= RELEASED;
                        level_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= RELEASED;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign kb.key_level = level_q;
    assign kb.key_busy  = (state_q == PRESS_WAIT) || (state_q == RELEASE_WAIT);
endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: an active-low and an active-high instance (DEBOUNCE_CYCLES=4) driven
// by directed and random pin activity, checked against a run-length reference model.
module tb_key_debounce;
    localparam int N = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    string phase;

    key_debounce_if kif0 ();
    key_debounce_if kif1 ();

    key_debounce #(.DEBOUNCE_CYCLES(N), .ACTIVE_LOW(1'b1)) dut0 (
        .clk (clk),
        .rst (rst),
        .kb  (kif0)
    );

    key_debounce #(.DEBOUNCE_CYCLES(N), .ACTIVE_LOW(1'b0)) dut1 (
        .clk (clk),
        .rst (rst),
        .kb  (kif1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pin delayed by two samples; level flips once N+1 consecutive
    // normalized samples disagree with it; busy while such a run is in progress.
    logic pol_low [2];
    logic m_pin1  [2];
    logic m_pin2  [2];
    logic m_lvl   [2];
    int   m_run   [2];

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s observed=%0b expected=%0b", phase, tag, obs, exp);
        end
    endtask

    task automatic model_edge(input int i, input logic pin, input logic r);
        logic smp;
        if (r) begin
            m_pin1[i] = pol_low[i];
            m_pin2[i] = pol_low[i];
            m_lvl[i]  = 1'b0;
            m_run[i]  = 0;
        end else begin
            smp = m_pin2[i] ^ pol_low[i];
            if (smp != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == N + 1) begin
                    m_lvl[i] = ~m_lvl[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
            m_pin2[i] = m_pin1[i];
            m_pin1[i] = pin;
        end
    endtask

    // One clock: drive, take the edge, then compare both instances on the falling edge.
    task automatic step(input logic a, input logic b, input logic r);
        kif0.key_in = a;
        kif1.key_in = b;
        rst         = r;
        @(posedge clk);
        model_edge(0, a, r);
        model_edge(1, b, r);
        @(negedge clk);
        chk("lvl_lo",  kif0.key_level, m_lvl[0]);
        chk("busy_lo", kif0.key_busy,  (m_run[0] != 0));
        chk("lvl_hi",  kif1.key_level, m_lvl[1]);
        chk("busy_hi", kif1.key_busy,  (m_run[1] != 0));
    endtask

    initial begin
        int   hold0;
        int   hold1;
        int   changes;
        logic pa;
        logic pb;
        logic prev;

        checks     = 0;
        errors     = 0;
        pol_low[0] = 1'b1;
        pol_low[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_pin1[i] = pol_low[i];
            m_pin2[i] = pol_low[i];
            m_lvl[i]  = 1'b0;
            m_run[i]  = 0;
        end

        phase = "reset";
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("rst_lvl_lo",  kif0.key_level, 1'b0);
        chk("rst_busy_lo", kif0.key_busy,  1'b0);
        chk("rst_lvl_hi",  kif1.key_level, 1'b0);
        chk("rst_busy_hi", kif1.key_busy,  1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);

        phase = "press";
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk("E_lvl_lo",  kif0.key_level, (i >= 6));
            chk("E_busy_lo", kif0.key_busy,  (i >= 2 && i < 6));
            chk("E_lvl_hi",  kif1.key_level, (i >= 6));
            chk("E_busy_hi", kif1.key_busy,  (i >= 2 && i < 6));
        end

        phase = "release";
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk("E_lvl_lo", kif0.key_level, (i < 6));
            chk("E_lvl_hi", kif1.key_level, (i < 6));
        end

        phase = "bounce";
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk("E_lvl_lo", kif0.key_level, (i >= 6));
        end

        phase = "glitch";
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk("held_lo", kif0.key_level, 1'b1);
        end

        phase = "rst_mid_wait";
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk("lvl_lo",  kif0.key_level, 1'b0);
        chk("busy_lo", kif0.key_busy,  1'b0);
        chk("busy_hi", kif1.key_busy,  1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk("E_lvl_lo", kif0.key_level, (i >= 6));
            chk("E_lvl_hi", kif1.key_level, (i >= 6));
        end

        phase = "random";
        hold0 = 0;
        hold1 = 0;
        pa    = 1'b1;
        pb    = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (hold0 == 0) begin
                pa    = ~pa;
                hold0 = $urandom_range(1, 9);
            end
            if (hold1 == 0) begin
                pb    = ~pb;
                hold1 = $urandom_range(1, 9);
            end
            hold0--;
            hold1--;
            step(pa, pb, ($urandom_range(0, 149) == 0));
        end

        phase = "long_hold";
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0);
        changes = 0;
        prev    = kif0.key_level;
        for (int i = 0; i < 1000; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (kif0.key_level !== prev) changes++;
            prev = kif0.key_level;
        end
        chk("final_lvl_lo", kif0.key_level, 1'b1);
        checks++;
        assert (changes == 1) else begin
            errors++;
            $error("FAIL %s/level_changes observed=%0d expected=1", phase, changes);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
